// File: rtl/si5345_cfg_pkg.sv
// rtl/si5345_cfg_pkg.sv - Si5345 configuration sequencer commands, state encodings and table entry fields
// Readback states exist only when SI5345_READBACK_EN is defined.
package si5345_cfg_pkg;

   localparam logic [7:0] CMD_SET_ADDR = 8'h00;
   localparam logic [7:0] CMD_WRITE    = 8'h40;
   localparam logic [7:0] CMD_READ     = 8'h80;
   localparam logic [7:0] PAGE_REG     = 8'h01;

   localparam int ENTRY_W       = 25;
   localparam int ENT_DATA_LSB  = 0;
   localparam int ENT_REG_LSB   = 8;
   localparam int ENT_PAGE_LSB  = 16;
   localparam int ENT_DELAY_BIT = 24;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_PG_A,
      ST_PG_D,
      ST_RG_A,
      ST_RG_D,
`ifdef SI5345_READBACK_EN
      ST_RB_A,
      ST_RB_R,
`endif
      ST_DELAY,
      ST_NEXT,
      ST_FINISH
   } seq_state_e;

   typedef enum logic [1:0] {
      TXN_IDLE,
      TXN_WAIT_BUSY,
      TXN_WAIT_DONE
   } txn_state_e;

   function automatic logic ent_is_delay(input logic [ENTRY_W-1:0] e);
      return e[ENT_DELAY_BIT];
   endfunction

   function automatic logic [7:0] ent_page(input logic [ENTRY_W-1:0] e);
      return e[ENT_PAGE_LSB +: 8];
   endfunction

   function automatic logic [7:0] ent_reg(input logic [ENTRY_W-1:0] e);
      return e[ENT_REG_LSB +: 8];
   endfunction

   function automatic logic [7:0] ent_data(input logic [ENTRY_W-1:0] e);
      return e[ENT_DATA_LSB +: 8];
   endfunction

endpackage

// File: rtl/si5345_spi_txn.sv
// rtl/si5345_spi_txn.sv - one SPI master transaction per request: start/busy/done handshake
// Command word and direction are held from start assertion until the master's done pulse.
module si5345_spi_txn
   import si5345_cfg_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   input  logic [15:0] word_i,
   input  logic        rw_i,
   output logic        spi_start_o,
   output logic [15:0] spi_dout_o,
   output logic        spi_rw_o,
   input  logic        spi_busy_i,
   input  logic        spi_done_i,
   input  logic [7:0]  spi_din_i,
   output logic        txn_done_o,
   output logic [7:0]  rd_byte_o
);

   txn_state_e  state_q, state_d;
   logic        start_q, start_d;
   logic [15:0] dout_q, dout_d;
   logic        rw_q, rw_d;
   logic [7:0]  rd_q, rd_d;

   always_comb begin
      state_d = state_q;
      start_d = start_q;
      dout_d  = dout_q;
      rw_d    = rw_q;
      rd_d    = rd_q;
      case (state_q)
         TXN_IDLE: begin
            if (req_i) begin
               state_d = TXN_WAIT_BUSY;
               start_d = 1'b1;
               dout_d  = word_i;
               rw_d    = rw_i;
            end
         end
         // The master re-triggers on a held level, so start must drop once it is busy.
         TXN_WAIT_BUSY: begin
            if (spi_busy_i) begin
               state_d = TXN_WAIT_DONE;
               start_d = 1'b0;
            end
         end
         TXN_WAIT_DONE: begin
            if (spi_done_i) begin
               state_d = TXN_IDLE;
               rd_d    = spi_din_i;
            end
         end
         default: begin
            state_d = TXN_IDLE;
            start_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TXN_IDLE;
         start_q <= 1'b0;
         dout_q  <= 16'h0000;
         rw_q    <= 1'b0;
         rd_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         dout_q  <= dout_d;
         rw_q    <= rw_d;
         rd_q    <= rd_d;
      end
   end

   assign spi_start_o = start_q;
   assign spi_dout_o  = dout_q;
   assign spi_rw_o    = rw_q;
   assign txn_done_o  = (state_q == TXN_WAIT_DONE) && spi_done_i;
   assign rd_byte_o   = txn_done_o ? spi_din_i : rd_q;

endmodule

// File: rtl/si5345_cfg_seq.sv
// rtl/si5345_cfg_seq.sv - walks a Si5345 register table and drives the SPI master with page/register writes
// Optional SI5345_READBACK_EN adds a read-back compare after every register write.
module si5345_cfg_seq
   import si5345_cfg_pkg::*;
#(
   parameter int          ADDR_W       = 9,
   parameter int          DELAY_CYCLES = 30_000_000,
   parameter logic [11:0] SPI_DIV2     = 12'd4
) (
   input  logic              sys_clk,
   input  logic              reset_n,
   input  logic              cfg_start_i,
   input  logic [ADDR_W:0]   num_entries_i,
   output logic              cfg_busy_o,
   output logic              cfg_done_o,
   output logic              cfg_err_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [24:0]       rom_data_i,
   output logic              spi_start_o,
   input  logic              spi_busy_i,
   input  logic              spi_done_i,
   output logic              spi_rw_o,
   output logic              spi_mlb_o,
   output logic [11:0]       spi_clk_div2_o,
   output logic [15:0]       spi_dout_o,
   input  logic [7:0]        spi_din_i
);

   localparam logic [31:0]     DLY_LAST = 32'(DELAY_CYCLES - 1);
   localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);

   seq_state_e        state_q, state_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [ADDR_W:0]   num_q, num_d;
   logic [ADDR_W:0]   idx_inc;
   logic              start_prev_q;
   logic              start_rise;
   logic [7:0]        page_q, page_d;
   logic              page_vld_q, page_vld_d;
   logic [7:0]        ent_page_q, ent_page_d;
   logic [7:0]        ent_reg_q, ent_reg_d;
   logic [7:0]        ent_data_q, ent_data_d;
   logic [31:0]       dly_cnt_q, dly_cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              req_q, req_d;
   logic [15:0]       word_q, word_d;
   logic              rw_q, rw_d;
   logic              txn_done;
   logic [7:0]        txn_rd_byte;
`ifdef SI5345_READBACK_EN
   logic              err_q, err_d;
`endif

   assign start_rise = cfg_start_i & ~start_prev_q;
   assign idx_inc    = idx_q + IDX_ONE;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      num_d      = num_q;
      page_d     = page_q;
      page_vld_d = page_vld_q;
      ent_page_d = ent_page_q;
      ent_reg_d  = ent_reg_q;
      ent_data_d = ent_data_q;
      dly_cnt_d  = dly_cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rom_addr_d = rom_addr_q;
      req_d      = 1'b0;
      word_d     = word_q;
      rw_d       = rw_q;
`ifdef SI5345_READBACK_EN
      err_d      = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_rise) begin
               num_d      = num_entries_i;
               idx_d      = '0;
               page_vld_d = 1'b0;
               rom_addr_d = '0;
`ifdef SI5345_READBACK_EN
               err_d      = 1'b0;
`endif
               if (num_entries_i == '0) begin
                  state_d = ST_FINISH;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = ST_FETCH;
                  busy_d  = 1'b1;
               end
            end
         end
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            ent_page_d = ent_page(rom_data_i);
            ent_reg_d  = ent_reg(rom_data_i);
            ent_data_d = ent_data(rom_data_i);
            if (ent_is_delay(rom_data_i)) begin
               state_d   = ST_DELAY;
               dly_cnt_d = 32'd0;
            end else if (page_vld_q && (page_q == ent_page(rom_data_i))) begin
               state_d = ST_RG_A;
               req_d   = 1'b1;
               word_d  = {CMD_SET_ADDR, ent_reg(rom_data_i)};
               rw_d    = 1'b0;
            end else begin
               state_d = ST_PG_A;
               req_d   = 1'b1;
               word_d  = {CMD_SET_ADDR, PAGE_REG};
               rw_d    = 1'b0;
            end
         end
         ST_PG_A: begin
            if (txn_done) begin
               state_d = ST_PG_D;
               req_d   = 1'b1;
               word_d  = {CMD_WRITE, ent_page_q};
            end
         end
         ST_PG_D: begin
            if (txn_done) begin
               page_d     = ent_page_q;
               page_vld_d = 1'b1;
               state_d    = ST_RG_A;
               req_d      = 1'b1;
               word_d     = {CMD_SET_ADDR, ent_reg_q};
            end
         end
         ST_RG_A: begin
            if (txn_done) begin
               state_d = ST_RG_D;
               req_d   = 1'b1;
               word_d  = {CMD_WRITE, ent_data_q};
            end
         end
         ST_RG_D: begin
            if (txn_done) begin
`ifdef SI5345_READBACK_EN
               state_d = ST_RB_A;
               req_d   = 1'b1;
               word_d  = {CMD_SET_ADDR, ent_reg_q};
`else
               state_d = ST_NEXT;
`endif
            end
         end
`ifdef SI5345_READBACK_EN
         ST_RB_A: begin
            if (txn_done) begin
               state_d = ST_RB_R;
               req_d   = 1'b1;
               word_d  = {CMD_READ, 8'h00};
               rw_d    = 1'b1;
            end
         end
         // A mismatch is only flagged; the table keeps going so the log shows every bad register.
         ST_RB_R: begin
            if (txn_done) begin
               if (txn_rd_byte != ent_data_q) err_d = 1'b1;
               state_d = ST_NEXT;
            end
         end
`endif
         ST_DELAY: begin
            if (dly_cnt_q == DLY_LAST) state_d = ST_NEXT;
            else dly_cnt_d = dly_cnt_q + 32'd1;
         end
         ST_NEXT: begin
            idx_d = idx_inc;
            if (idx_inc == num_q) begin
               state_d = ST_FINISH;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d    = ST_FETCH;
               rom_addr_d = idx_inc[ADDR_W-1:0];
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         num_q        <= '0;
         start_prev_q <= 1'b0;
         page_q       <= 8'h00;
         page_vld_q   <= 1'b0;
         ent_page_q   <= 8'h00;
         ent_reg_q    <= 8'h00;
         ent_data_q   <= 8'h00;
         dly_cnt_q    <= 32'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         rom_addr_q   <= '0;
         req_q        <= 1'b0;
         word_q       <= 16'h0000;
         rw_q         <= 1'b0;
`ifdef SI5345_READBACK_EN
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         num_q        <= num_d;
         start_prev_q <= cfg_start_i;
         page_q       <= page_d;
         page_vld_q   <= page_vld_d;
         ent_page_q   <= ent_page_d;
         ent_reg_q    <= ent_reg_d;
         ent_data_q   <= ent_data_d;
         dly_cnt_q    <= dly_cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         rom_addr_q   <= rom_addr_d;
         req_q        <= req_d;
         word_q       <= word_d;
         rw_q         <= rw_d;
`ifdef SI5345_READBACK_EN
         err_q        <= err_d;
`endif
      end
   end

   si5345_spi_txn u_txn (
      .clk         (sys_clk),
      .rst_n       (reset_n),
      .req_i       (req_q),
      .word_i      (word_q),
      .rw_i        (rw_q),
      .spi_start_o (spi_start_o),
      .spi_dout_o  (spi_dout_o),
      .spi_rw_o    (spi_rw_o),
      .spi_busy_i  (spi_busy_i),
      .spi_done_i  (spi_done_i),
      .spi_din_i   (spi_din_i),
      .txn_done_o  (txn_done),
      .rd_byte_o   (txn_rd_byte)
   );

`ifdef SI5345_READBACK_EN
   assign cfg_err_o = err_q;
`else
   logic unused_rd_byte;
   assign unused_rd_byte = ^txn_rd_byte;
   assign cfg_err_o      = 1'b0;
`endif

   assign cfg_busy_o     = busy_q;
   assign cfg_done_o     = done_q;
   assign rom_addr_o     = rom_addr_q;
   assign spi_mlb_o      = 1'b1;
   assign spi_clk_div2_o = SPI_DIV2;

endmodule

// File: tb/tb_si5345_cfg_seq.sv
// tb/tb_si5345_cfg_seq.sv - scoreboard bench for si5345_cfg_seq with ROM and SPI master models
module tb_si5345_cfg_seq;

   localparam int ADDR_W = 9;
   localparam int DLY    = 100;

   logic              sys_clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              cfg_start_i = 1'b0;
   logic [ADDR_W:0]   num_entries_i = '0;
   logic              cfg_busy_o, cfg_done_o, cfg_err_o;
   logic [ADDR_W-1:0] rom_addr_o;
   logic [24:0]       rom_data_i = '0;
   logic              spi_start_o, spi_rw_o, spi_mlb_o;
   logic              spi_busy_i = 1'b0;
   logic              spi_done_i = 1'b0;
   logic [11:0]       spi_clk_div2_o;
   logic [15:0]       spi_dout_o;
   logic [7:0]        spi_din_i = 8'h00;

   always #5 sys_clk = ~sys_clk;

   si5345_cfg_seq #(.ADDR_W(ADDR_W), .DELAY_CYCLES(DLY), .SPI_DIV2(12'd4)) dut (
      .sys_clk        (sys_clk),
      .reset_n        (reset_n),
      .cfg_start_i    (cfg_start_i),
      .num_entries_i  (num_entries_i),
      .cfg_busy_o     (cfg_busy_o),
      .cfg_done_o     (cfg_done_o),
      .cfg_err_o      (cfg_err_o),
      .rom_addr_o     (rom_addr_o),
      .rom_data_i     (rom_data_i),
      .spi_start_o    (spi_start_o),
      .spi_busy_i     (spi_busy_i),
      .spi_done_i     (spi_done_i),
      .spi_rw_o       (spi_rw_o),
      .spi_mlb_o      (spi_mlb_o),
      .spi_clk_div2_o (spi_clk_div2_o),
      .spi_dout_o     (spi_dout_o),
      .spi_din_i      (spi_din_i)
   );

`ifdef SI5345_READBACK_EN
   localparam int TX_PER_WR = 4;
`else
   localparam int TX_PER_WR = 2;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [16:0] exp_q[$];
   int          start_cyc[$];
   int          cyc = 0;
   int          n_starts = 0;
   logic        corrupt_en = 1'b0;
   logic [24:0] rom [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] rom_a_prev = '0;
   logic        m_busy = 1'b0;
   int          m_cnt = 0;
   logic [7:0]  last_wdata = 8'h00;
   logic        prev_start = 1'b0;
   logic [15:0] cap_dout = 16'h0000;
   logic [16:0] mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ROM with one cycle of read latency
   initial forever begin
      @(posedge sys_clk); #1;
      rom_data_i = rom[rom_a_prev];
      rom_a_prev = rom_addr_o;
   end

   // SPI master: busy for 4 cycles, then a done pulse; restarts if start is still high when idle
   initial forever begin
      @(posedge sys_clk); #1;
      spi_done_i = 1'b0;
      if (!reset_n) begin
         m_busy     = 1'b0;
         spi_busy_i = 1'b0;
      end else if (m_busy) begin
         if (m_cnt == 0) begin
            m_busy     = 1'b0;
            spi_busy_i = 1'b0;
            spi_done_i = 1'b1;
            if (spi_rw_o) spi_din_i = (corrupt_en && last_wdata == 8'hC0) ? 8'hC1 : last_wdata;
            else if (spi_dout_o[15:8] == 8'h40) last_wdata = spi_dout_o[7:0];
         end else begin
            m_cnt--;
         end
      end else if (spi_start_o) begin
         m_busy     = 1'b1;
         spi_busy_i = 1'b1;
         m_cnt      = 3;
      end
   end

   // Monitor: pop the expected word on each new start request
   initial forever begin
      @(negedge sys_clk);
      cyc++;
      if (spi_start_o && !prev_start) begin
         n_starts++;
         start_cyc.push_back(cyc);
         cap_dout = spi_dout_o;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spi_word: got rw=%0b word 0x%04h, expected no transaction", spi_rw_o, spi_dout_o);
         end else begin
            mon_exp = exp_q.pop_front();
            check("spi_word", {15'd0, spi_rw_o, spi_dout_o}, {15'd0, mon_exp});
         end
      end
      if (spi_done_i && reset_n) check("dout_stable", {16'd0, spi_dout_o}, {16'd0, cap_dout});
      prev_start = spi_start_o;
   end

   task automatic push_w(input logic rw, input logic [15:0] w);
      exp_q.push_back({rw, w});
   endtask

   task automatic push_entry(input logic [7:0] pg, input logic [7:0] rg, input logic [7:0] dt, input bit new_page);
      if (new_page) begin
         push_w(1'b0, 16'h0001);
         push_w(1'b0, {8'h40, pg});
      end
      push_w(1'b0, {8'h00, rg});
      push_w(1'b0, {8'h40, dt});
`ifdef SI5345_READBACK_EN
      push_w(1'b0, {8'h00, rg});
      push_w(1'b1, 16'h8000);
`endif
   endtask

   // Called just after a negedge; returns cycles from start to the done pulse.
   task automatic run_cfg(input string name, input int n, output int lat);
      int busy_low;
      busy_low = 0;
      lat = 1;
      num_entries_i = n[ADDR_W:0];
      cfg_start_i = 1'b1;
      @(negedge sys_clk);
      cfg_start_i = 1'b0;
      if (n > 0) check({name, "_busy_rise"}, {31'd0, cfg_busy_o}, 32'd1);
      while (!cfg_done_o && lat < 20000) begin
         @(negedge sys_clk);
         lat++;
         if (!cfg_done_o && !cfg_busy_o) busy_low++;
      end
      check({name, "_done_pulse"}, {31'd0, cfg_done_o}, 32'd1);
      check({name, "_busy_fall"}, {31'd0, cfg_busy_o}, 32'd0);
      if (n > 0) check({name, "_busy_held"}, busy_low, 32'd0);
      @(negedge sys_clk);
      check({name, "_done_1cyc"}, {31'd0, cfg_done_o}, 32'd0);
      check({name, "_queue_empty"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      int lat;
      int base;
      int k;
      for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 25'd0;

      repeat (3) @(negedge sys_clk);
      check("rst_busy", {31'd0, cfg_busy_o}, 32'd0);
      check("rst_done", {31'd0, cfg_done_o}, 32'd0);
      check("rst_err", {31'd0, cfg_err_o}, 32'd0);
      check("rst_start_rw", {30'd0, spi_start_o, spi_rw_o}, 32'd0);
      check("rst_addr_dout", {7'd0, rom_addr_o, spi_dout_o}, 32'd0);
      check("rst_mlb_div", {19'd0, spi_mlb_o, spi_clk_div2_o}, {19'd0, 1'b1, 12'd4});
      reset_n = 1'b1;
      repeat (2) @(negedge sys_clk);

      // Single entry: page select then register write
      rom[0] = {1'b0, 8'h0B, 8'h24, 8'hC0};
      push_w(1'b0, 16'h0001);
      push_w(1'b0, 16'h400B);
      push_w(1'b0, 16'h0024);
      push_w(1'b0, 16'h40C0);
`ifdef SI5345_READBACK_EN
      push_w(1'b0, 16'h0024);
      push_w(1'b1, 16'h8000);
`endif
      run_cfg("single", 1, lat);

      // Two entries on the same page: page select only once
      rom[1] = {1'b0, 8'h0B, 8'h25, 8'h11};
      base = n_starts;
      push_entry(8'h0B, 8'h24, 8'hC0, 1'b1);
      push_entry(8'h0B, 8'h25, 8'h11, 1'b0);
      run_cfg("same_page", 2, lat);
      check("same_page_txns", n_starts - base, 2 + 2 * TX_PER_WR);

      // Page change between entries
      rom[0] = {1'b0, 8'h00, 8'h0B, 8'h5A};
      rom[1] = {1'b0, 8'h02, 8'h35, 8'hA5};
      push_entry(8'h00, 8'h0B, 8'h5A, 1'b1);
      push_entry(8'h02, 8'h35, 8'hA5, 1'b1);
      run_cfg("page_change", 2, lat);

      // Delay entry between two writes
      rom[0] = {1'b0, 8'h0B, 8'h30, 8'h01};
      rom[1] = {1'b1, 8'h00, 8'h00, 8'h00};
      rom[2] = {1'b0, 8'h0B, 8'h31, 8'h02};
      base = start_cyc.size();
      push_entry(8'h0B, 8'h30, 8'h01, 1'b1);
      push_entry(8'h0B, 8'h31, 8'h02, 1'b0);
      run_cfg("delay", 3, lat);
      k = base + 2 + TX_PER_WR;
      if (start_cyc.size() > k) begin
         check("delay_gap_min", (start_cyc[k] - start_cyc[k-1]) >= DLY + 3, 32'd1);
         check("delay_gap_max", (start_cyc[k] - start_cyc[k-1]) <= DLY + 20, 32'd1);
      end else begin
         check("delay_txn_count", start_cyc.size(), k + 1);
      end

      // Zero entries: immediate completion, no SPI traffic
      base = n_starts;
      run_cfg("zero", 0, lat);
      check("zero_latency_le2", lat <= 2, 32'd1);
      check("zero_no_spi", n_starts - base, 32'd0);

      // Readback mismatch (err stays 0 when readback is not built in)
      rom[0] = {1'b0, 8'h0B, 8'h24, 8'hC0};
      rom[1] = {1'b0, 8'h0B, 8'h25, 8'h11};
      corrupt_en = 1'b1;
      push_entry(8'h0B, 8'h24, 8'hC0, 1'b1);
      push_entry(8'h0B, 8'h25, 8'h11, 1'b0);
      run_cfg("rb_bad", 2, lat);
`ifdef SI5345_READBACK_EN
      check("rb_err_set", {31'd0, cfg_err_o}, 32'd1);
      repeat (5) @(negedge sys_clk);
      check("rb_err_sticky", {31'd0, cfg_err_o}, 32'd1);
`else
      check("rb_err_tied", {31'd0, cfg_err_o}, 32'd0);
`endif
      corrupt_en = 1'b0;
      push_entry(8'h0B, 8'h24, 8'hC0, 1'b1);
      push_entry(8'h0B, 8'h25, 8'h11, 1'b0);
      run_cfg("rb_good", 2, lat);
      check("rb_err_cleared", {31'd0, cfg_err_o}, 32'd0);

      // Reset during the second transaction, then restart from scratch
      rom[0] = {1'b0, 8'h0B, 8'h24, 8'hC0};
      push_entry(8'h0B, 8'h24, 8'hC0, 1'b1);
      base = n_starts;
      num_entries_i = 1;
      cfg_start_i = 1'b1;
      @(negedge sys_clk);
      cfg_start_i = 1'b0;
      k = 0;
      while (n_starts < base + 2 && k < 200) begin
         @(negedge sys_clk);
         k++;
      end
      check("midrst_reached_txn2", n_starts - base, 32'd2);
      reset_n = 1'b0;
      exp_q.delete();
      @(negedge sys_clk);
      check("midrst_start", {31'd0, spi_start_o}, 32'd0);
      check("midrst_busy", {31'd0, cfg_busy_o}, 32'd0);
      check("midrst_addr_dout", {7'd0, rom_addr_o, spi_dout_o}, 32'd0);
      repeat (2) @(negedge sys_clk);
      reset_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      base = n_starts;
      push_entry(8'h0B, 8'h24, 8'hC0, 1'b1);
      run_cfg("restart", 1, lat);
      check("restart_txns", n_starts - base, 2 + TX_PER_WR);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
